// File: rtl/qam_symbol_mapper_pkg.sv
// Shared types and constants for the QAM symbol mapper: modulation codes,
// symbols per word, slicer states and the 16QAM Gray pair-to-level map.
package qam_pkg;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_16QAM = 1'b1;

  localparam int SYMS_QPSK  = 8;
  localparam int SYMS_16QAM = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_NEXT = 2'd2
  } slicerState_e;

  // Gray-coded bit pair to constellation level in units of LEVEL_STEP.
  function automatic logic signed [2:0] grayLevel(input logic [1:0] pair);
    case (pair)
      2'b00:   grayLevel = -3'sd3;
      2'b01:   grayLevel = -3'sd1;
      2'b11:   grayLevel = 3'sd1;
      default: grayLevel = 3'sd3;
    endcase
  endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// Word input / symbol output bundle of the QAM symbol mapper.
// QAM_MAP_STATS_EN adds the symbol and underrun statistics counters.
interface qam_symbol_mapper_if #(
  parameter int OUT_W = 8
);
  logic                    word_valid;
  logic [15:0]             word_in;
  logic                    mod_sel;
  logic                    sym_tick;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    sym_valid;
  logic                    underrun;
  logic                    overflow;
`ifdef QAM_MAP_STATS_EN
  logic [15:0]             sym_count;
  logic [7:0]              underrun_count;

  modport master (
    output word_valid, word_in, mod_sel, sym_tick,
    input  i_out, q_out, sym_valid, underrun, overflow, sym_count, underrun_count
  );
  modport slave (
    input  word_valid, word_in, mod_sel, sym_tick,
    output i_out, q_out, sym_valid, underrun, overflow, sym_count, underrun_count
  );
`else
  modport master (
    output word_valid, word_in, mod_sel, sym_tick,
    input  i_out, q_out, sym_valid, underrun, overflow
  );
  modport slave (
    input  word_valid, word_in, mod_sel, sym_tick,
    output i_out, q_out, sym_valid, underrun, overflow
  );
`endif
endinterface

// File: rtl/qam_symbol_mapper_word_fifo2.sv
// Two-entry 16-bit word FIFO; the head word is visible combinationally so a
// word can be popped in the cycle after it was written.
module qam_word_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic [1:0]  count_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [15:0] mem_q [2];
  logic        wrPtr_q, rdPtr_q;
  logic [1:0]  count_q;
  logic        pushOk, popOk;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign popOk  = pop_i && !empty_o;
  assign pushOk = push_i && (!full_o || popOk);

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pushOk) wrPtr_q <= ~wrPtr_q;
      if (popOk)  rdPtr_q <= ~rdPtr_q;
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// QPSK/16QAM symbol mapper: buffers 16-bit words and emits Gray-mapped I/Q
// amplitudes, LSB first, one symbol per sym_tick. Option: QAM_MAP_STATS_EN.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int OUT_W      = 8,
  parameter int LEVEL_STEP = 32
) (
  input logic                clk,
  input logic                rst_n,
  qam_symbol_mapper_if.slave bus
);

  localparam logic signed [OUT_W-1:0] AMP2 = OUT_W'(2 * LEVEL_STEP);

  slicerState_e            state_q, state_d;
  logic [15:0]             shiftReg_q, shiftReg_d;
  logic                    mode_q, mode_d;
  logic [2:0]              symIdx_q, symIdx_d;
  logic signed [OUT_W-1:0] iOut_q, iOut_d, qOut_q, qOut_d;
  logic                    symValid_q, symValid_d;
  logic                    underrun_q, underrun_d;
  logic                    overflow_q, overflow_d;

  logic        fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [1:0]  fifoCount;
  logic [15:0] fifoData;

  logic [15:0]             srcWord;
  logic                    srcMode;
  logic signed [OUT_W-1:0] mapI, mapQ;

  assign fifoPush = bus.word_valid && (!fifoFull || fifoPop);

  qam_word_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  (bus.word_in),
    .data_o  (fifoData),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // While running, the current symbol sits in the low bits of the shift register;
  // otherwise it comes straight from the FIFO head with the live mod_sel.
  always_comb begin
    srcWord = (state_q == RUN) ? shiftReg_q : fifoData;
    srcMode = (state_q == RUN) ? mode_q : bus.mod_sel;
    if (srcMode == MOD_QPSK) begin
      mapI = srcWord[0] ? AMP2 : -AMP2;
      mapQ = srcWord[1] ? AMP2 : -AMP2;
    end else begin
      mapI = OUT_W'(int'(grayLevel(srcWord[1:0])) * LEVEL_STEP);
      mapQ = OUT_W'(int'(grayLevel(srcWord[3:2])) * LEVEL_STEP);
    end
  end

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    mode_d     = mode_q;
    symIdx_d   = symIdx_q;
    iOut_d     = iOut_q;
    qOut_d     = qOut_q;
    symValid_d = 1'b0;
    underrun_d = 1'b0;
    fifoPop    = 1'b0;
    overflow_d = overflow_q ||
                 (bus.word_valid && (fifoCount == 2'd2) && !fifoPop);
    if (bus.sym_tick) begin
      if (state_q == RUN) begin
        iOut_d     = mapI;
        qOut_d     = mapQ;
        symValid_d = 1'b1;
        shiftReg_d = (mode_q == MOD_QPSK) ? (shiftReg_q >> 2) : (shiftReg_q >> 4);
        if (symIdx_q == ((mode_q == MOD_QPSK) ? 3'(SYMS_QPSK - 1) : 3'(SYMS_16QAM - 1)))
          state_d = LOAD_NEXT;
        else
          symIdx_d = symIdx_q + 3'd1;
      end else if (!fifoEmpty) begin
        fifoPop    = 1'b1;
        mode_d     = bus.mod_sel;
        iOut_d     = mapI;
        qOut_d     = mapQ;
        symValid_d = 1'b1;
        shiftReg_d = (bus.mod_sel == MOD_QPSK) ? (fifoData >> 2) : (fifoData >> 4);
        symIdx_d   = 3'd1;
        state_d    = RUN;
      end else begin
        underrun_d = 1'b1;
        iOut_d     = '0;
        qOut_d     = '0;
        state_d    = IDLE;
      end
      overflow_d = overflow_q ||
                   (bus.word_valid && (fifoCount == 2'd2) && !fifoPop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      mode_q     <= MOD_QPSK;
      symIdx_q   <= '0;
      iOut_q     <= '0;
      qOut_q     <= '0;
      symValid_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      mode_q     <= mode_d;
      symIdx_q   <= symIdx_d;
      iOut_q     <= iOut_d;
      qOut_q     <= qOut_d;
      symValid_q <= symValid_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.i_out     = iOut_q;
  assign bus.q_out     = qOut_q;
  assign bus.sym_valid = symValid_q;
  assign bus.underrun  = underrun_q;
  assign bus.overflow  = overflow_q;

`ifdef QAM_MAP_STATS_EN
  logic [15:0] symCount_q;
  logic [7:0]  underrunCount_q;

  // Counters advance on the same edge that raises sym_valid / underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      symCount_q      <= '0;
      underrunCount_q <= '0;
    end else begin
      if (symValid_d) symCount_q <= symCount_q + 16'd1;
      if (underrun_d && (underrunCount_q != 8'hFF)) underrunCount_q <= underrunCount_q + 8'd1;
    end
  end

  assign bus.sym_count      = symCount_q;
  assign bus.underrun_count = underrunCount_q;
`endif

endmodule
